// File: rtl/r2_pair_scheduler_if.sv
// Result stream from the pair scheduler to its consumer: {nb_id, r2, in_range} with valid/ready.
interface r2_pair_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_nb_id;
    logic [DATA_WIDTH-1:0] out_r2;
    logic                  out_in_range;

    modport master (output out_valid, out_nb_id, out_r2, out_in_range, input out_ready);
    modport slave  (input out_valid, out_nb_id, out_r2, out_in_range, output out_ready);
endinterface

// File: rtl/r2_pair_scheduler.sv
// Streams one reference particle against a neighbour list through r2_compute into a result FIFO.
// Optional macro CUTOFF_FILTER_EN: push only results inside the cutoff radius.
//
// state    | meaning
// IDLE     | waiting for start
// REF_RD   | reference read strobe issued
// REF_LD   | reference coordinates captured from read data
// STREAM   | one neighbour read per cycle while credits allow
// DRAIN    | all pairs issued, waiting for pipeline to empty
// DONE     | done pulse, back to IDLE
module r2_pair_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int R2_LATENCY = 17,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   ref_addr,
    input  logic [ADDR_WIDTH-1:0]   nb_base_addr,
    input  logic [ADDR_WIDTH:0]     nb_count,
    input  logic [DATA_WIDTH-1:0]   cutoff2,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [3*DATA_WIDTH-1:0] mem_rd_data,
    output logic                    r2c_enable,
    output logic [DATA_WIDTH-1:0]   refx,
    output logic [DATA_WIDTH-1:0]   refy,
    output logic [DATA_WIDTH-1:0]   refz,
    output logic [DATA_WIDTH-1:0]   posx,
    output logic [DATA_WIDTH-1:0]   posy,
    output logic [DATA_WIDTH-1:0]   posz,
    input  logic [DATA_WIDTH-1:0]   r2c_r2,
    input  logic                    r2c_r2_valid,
    r2_pair_scheduler_if.master     res
);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 2;

    typedef enum logic [2:0] {S_IDLE, S_REF_RD, S_REF_LD, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   idx;
    logic [DATA_WIDTH-2:0] cutoff_mag;
    logic                  unused_cutoff_sign;
    logic                  nb_rd;
    logic [ADDR_WIDTH-1:0] rd_id;
    logic [ADDR_WIDTH-1:0] en_id;
    logic [CW-1:0]         inflight;
    logic [FW:0]           fifo_cnt;
    logic [FW-1:0]         wptr;
    logic [FW-1:0]         rptr;
    logic [CW-1:0]         outstanding;
    logic                  credit_ok;
    logic                  push;
    logic                  pop;
    logic                  r2_in_range;
    logic [DATA_WIDTH-2:0] r2_mag;

    logic [R2_LATENCY-1:0] tag_v;
    logic [ADDR_WIDTH-1:0] tag_id [R2_LATENCY];

    logic [ADDR_WIDTH-1:0] fifo_id [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_r2 [FIFO_DEPTH];
    logic                  fifo_ir [FIFO_DEPTH];

    assign unused_cutoff_sign = cutoff2[DATA_WIDTH-1];

    // Everything issued but not yet popped: FIFO entries, pipeline, read and data phases.
    assign outstanding = CW'(fifo_cnt) + inflight + CW'(nb_rd) + CW'(r2c_enable);
    assign credit_ok   = outstanding < CW'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            nb_rd       <= 1'b0;
            rd_id       <= '0;
            base_q      <= '0;
            count_q     <= '0;
            idx         <= '0;
            cutoff_mag  <= '0;
            refx        <= '0;
            refy        <= '0;
            refz        <= '0;
        end else begin
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            nb_rd     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q      <= nb_base_addr;
                        count_q     <= nb_count;
                        cutoff_mag  <= cutoff2[DATA_WIDTH-2:0];
                        idx         <= '0;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= ref_addr;
                        busy        <= 1'b1;
                        state       <= S_REF_RD;
                    end
                end
                S_REF_RD: state <= S_REF_LD;
                S_REF_LD: begin
                    {refz, refy, refx} <= mem_rd_data;
                    done  <= (count_q == '0);
                    state <= (count_q == '0) ? S_DONE : S_STREAM;
                end
                S_STREAM: begin
                    if (credit_ok) begin
                        mem_rd_en   <= 1'b1;
                        nb_rd       <= 1'b1;
                        mem_rd_addr <= base_q + idx[ADDR_WIDTH-1:0];
                        rd_id       <= idx[ADDR_WIDTH-1:0];
                        idx         <= idx + 1'b1;
                        if (idx == count_q - 1'b1) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (inflight == '0 && !nb_rd && !r2c_enable) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign posx = r2c_enable ? mem_rd_data[DATA_WIDTH-1:0]            : '0;
    assign posy = r2c_enable ? mem_rd_data[2*DATA_WIDTH-1:DATA_WIDTH]  : '0;
    assign posz = r2c_enable ? mem_rd_data[3*DATA_WIDTH-1:2*DATA_WIDTH] : '0;

    // Negative zero has the sign bit set but is still a zero distance.
    assign r2_mag      = r2c_r2[DATA_WIDTH-2:0];
    assign r2_in_range = (!r2c_r2[DATA_WIDTH-1] || r2_mag == '0)
                       && (r2c_r2[DATA_WIDTH-2 -: 8] != 8'hFF)
                       && (r2_mag <= cutoff_mag);

`ifdef CUTOFF_FILTER_EN
    assign push = r2c_r2_valid && r2_in_range;
`else
    assign push = r2c_r2_valid;
`endif
    assign pop = res.out_valid && res.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r2c_enable <= 1'b0;
            en_id      <= '0;
            inflight   <= '0;
            tag_v      <= '0;
            for (int i = 0; i < R2_LATENCY; i++) tag_id[i] <= '0;
            fifo_cnt   <= '0;
            wptr       <= '0;
            rptr       <= '0;
        end else begin
            r2c_enable <= nb_rd;
            en_id      <= rd_id;
            if (r2c_enable && !r2c_r2_valid)      inflight <= inflight + 1'b1;
            else if (!r2c_enable && r2c_r2_valid) inflight <= inflight - 1'b1;
            tag_v     <= {tag_v[R2_LATENCY-2:0], r2c_enable};
            tag_id[0] <= en_id;
            for (int i = 1; i < R2_LATENCY; i++) tag_id[i] <= tag_id[i-1];
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wptr] <= tag_id[R2_LATENCY-1];
            fifo_r2[wptr] <= r2c_r2;
            fifo_ir[wptr] <= r2_in_range;
        end
    end

    assign res.out_valid    = (fifo_cnt != '0);
    assign res.out_nb_id    = res.out_valid ? fifo_id[rptr] : '0;
    assign res.out_r2       = res.out_valid ? fifo_r2[rptr] : '0;
    assign res.out_in_range = res.out_valid && fifo_ir[rptr];

    tag_align: assert property (@(posedge clk) disable iff (!rst) r2c_r2_valid |-> tag_v[R2_LATENCY-1]);
endmodule

// File: tb/tb_r2_pair_scheduler.sv
// Directed bench for r2_pair_scheduler with a fixed-latency stand-in for r2_compute.
module tb_r2_pair_scheduler;
    localparam int DW  = 32;
    localparam int AW  = 9;
    localparam int LAT = 17;
    localparam int FD  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start;
    logic [AW-1:0]   ref_addr, nb_base_addr, mem_rd_addr;
    logic [AW:0]     nb_count;
    logic [DW-1:0]   cutoff2, refx, refy, refz, posx, posy, posz, r2c_r2;
    logic            busy, done, mem_rd_en, r2c_enable, r2c_r2_valid;
    logic [3*DW-1:0] mem_rd_data;
    logic [3*DW-1:0] mem [512];

    always #5 clk = ~clk;

    r2_pair_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rif ();

    r2_pair_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .R2_LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .start(start), .ref_addr(ref_addr), .nb_base_addr(nb_base_addr),
        .nb_count(nb_count), .cutoff2(cutoff2), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .r2c_enable(r2c_enable),
        .refx(refx), .refy(refy), .refz(refz), .posx(posx), .posy(posy), .posz(posz),
        .r2c_r2(r2c_r2), .r2c_r2_valid(r2c_r2_valid), .res(rif)
    );

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    // Stand-in r2_compute: the reference is the origin in every streamed job, so r2 = x*x
    // for the small table below; any other x is taken as an already-computed r2.
    function automatic logic [31:0] sq(input logic [31:0] x);
        case (x)
            32'h3F80_0000: sq = 32'h3F80_0000;
            32'h4000_0000: sq = 32'h4080_0000;
            32'h4040_0000: sq = 32'h4110_0000;
            32'h4080_0000: sq = 32'h4180_0000;
            default:       sq = x;
        endcase
    endfunction

    logic [DW-1:0]  pipe_r2 [LAT];
    logic [LAT-1:0] pipe_v;
    always @(posedge clk or negedge rst) begin
        if (!rst) pipe_v <= '0;
        else      pipe_v <= {pipe_v[LAT-2:0], r2c_enable};
    end
    always @(posedge clk) begin
        pipe_r2[0] <= sq(posx);
        for (int i = 1; i < LAT; i++) pipe_r2[i] <= pipe_r2[i-1];
    end
    assign r2c_r2_valid = pipe_v[LAT-1];
    assign r2c_r2       = pipe_r2[LAT-1];

    typedef struct packed {
        logic [AW-1:0] id;
        logic [31:0]   r2;
        logic          ir;
    } res_t;

    res_t got[$];
    int   n_en   = 0;
    int   n_done = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    always @(negedge clk) begin
        if (rif.out_valid && rif.out_ready) got.push_back(res_t'{rif.out_nb_id, rif.out_r2, rif.out_in_range});
        if (r2c_enable) n_en++;
        if (done) n_done++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_job(input logic [AW-1:0] ra, input logic [AW-1:0] ba,
                             input logic [AW:0] cnt, input logic [DW-1:0] cut);
        ref_addr = ra; nb_base_addr = ba; nb_count = cnt; cutoff2 = cut;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int  n0   = n_done;
        bit  seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (n_done != n0) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    function automatic res_t got_at(input int i);
        if (i < got.size()) return got[i];
        return '1;
    endfunction

    initial begin
        int      e0, d0, n_exp;
        logic [8:0] a;
        res_t    r;
        logic [31:0] r2e [4];
        logic        ire [4];

        start = 1'b0; ref_addr = '0; nb_base_addr = '0; nb_count = '0; cutoff2 = '0;
        rif.out_ready = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        mem[5] = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        for (int i = 0; i < 4; i++) mem[100+i] = {64'd0, 32'h3F80_0000 + 32'(i == 0 ? 0 : (i == 1 ? 32'h0080_0000 : (i == 2 ? 32'h00C0_0000 : 32'h0100_0000)))};

        // Reset state
        tick(3);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_en", 64'(mem_rd_en), 64'd0);
        check("rst_r2c_en", 64'(r2c_enable), 64'd0);
        check("rst_out_valid", 64'(rif.out_valid), 64'd0);
        rst = 1'b1;
        tick(2);

        // nb_count = 0: reference read only, done three cycles after start
        e0 = n_en; d0 = n_done;
        start_job(9'd5, 9'd0, 10'd0, 32'h4110_0000);
        check("t1_rd_en", 64'(mem_rd_en), 64'd1);
        check("t1_rd_addr", 64'(mem_rd_addr), 64'd5);
        check("t1_busy", 64'(busy), 64'd1);
        tick(1);
        check("t1_rd_en_off", 64'(mem_rd_en), 64'd0);
        check("t1_done_early", 64'(done), 64'd0);
        tick(1);
        check("t1_done", 64'(done), 64'd1);
        check("t1_refx", 64'(refx), 64'h1111_1111);
        check("t1_refz", 64'(refz), 64'h3333_3333);
        tick(1);
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_busy_clr", 64'(busy), 64'd0);
        check("t1_no_enable", 64'(n_en - e0), 64'd0);
        check("t1_done_count", 64'(n_done - d0), 64'd1);

        // Four neighbours at x = 1..4, cutoff2 = 9.0
        r2e = '{32'h3F80_0000, 32'h4080_0000, 32'h4110_0000, 32'h4180_0000};
        ire = '{1'b1, 1'b1, 1'b1, 1'b0};
        rif.out_ready = 1'b1;
        got.delete();
        d0 = n_done;
        start_job(9'd300, 9'd100, 10'd4, 32'h4110_0000);
        wait_done("t2_done_timeout", 200);
        tick(4);
`ifdef CUTOFF_FILTER_EN
        n_exp = 3;
`else
        n_exp = 4;
`endif
        check("t2_count", 64'(got.size()), 64'(n_exp));
        for (int i = 0; i < n_exp; i++) begin
            r = got_at(i);
            check("t2_item", {23'd0, r.id, r.r2}, {23'd0, 9'(i), r2e[i]});
`ifdef CUTOFF_FILTER_EN
            check("t2_in_range", 64'(r.ir), 64'd1);
`else
            check("t2_in_range", 64'(r.ir), 64'(ire[i]));
`endif
        end
        check("t2_done_once", 64'(n_done - d0), 64'd1);

        // 64 neighbours, wrapping addresses, consumer stalled: credits cap issue at FIFO depth
        for (int i = 0; i < 64; i++) begin
            a = 9'(480 + i);
            mem[a] = {64'd0, 32'h4100_0000 + 32'(i)};
        end
        rif.out_ready = 1'b0;
        got.delete();
        e0 = n_en; d0 = n_done;
        start_job(9'd300, 9'd480, 10'd64, 32'h4110_0000);
        tick(80);
        check("t3_stall_issues", 64'(n_en - e0), 64'd16);
        check("t3_stall_busy", 64'(busy), 64'd1);
        check("t3_stall_valid", 64'(rif.out_valid), 64'd1);
        check("t3_stall_rd_en", 64'(mem_rd_en), 64'd0);
        check("t3_stall_no_done", 64'(n_done - d0), 64'd0);
        rif.out_ready = 1'b1;
        wait_done("t3_done_timeout", 800);
        tick(4);
        check("t3_count", 64'(got.size()), 64'd64);
        for (int i = 0; i < 64; i++) begin
            r = got_at(i);
            check("t3_item", {23'd0, r.id, r.r2}, {23'd0, 9'(i), 32'h4100_0000 + 32'(i)});
        end
        check("t3_issues", 64'(n_en - e0), 64'd64);
        check("t3_done_once", 64'(n_done - d0), 64'd1);
        check("t3_fifo_empty", 64'(rif.out_valid), 64'd0);

        // start while busy is ignored; a later start latches fresh inputs
        mem[10] = {64'd0, 32'h40A0_0000};
        mem[11] = {64'd0, 32'h40B0_0000};
        mem[20] = {64'd0, 32'h40C0_0000};
        mem[21] = {64'd0, 32'h40D0_0000};
        mem[22] = {64'd0, 32'h40E0_0000};
        got.delete();
        e0 = n_en; d0 = n_done;
        start_job(9'd300, 9'd10, 10'd2, 32'h4110_0000);
        start_job(9'd300, 9'd20, 10'd5, 32'h4110_0000);
        wait_done("t4a_done_timeout", 200);
        tick(4);
        check("t4a_count", 64'(got.size()), 64'd2);
        r = got_at(0);
        check("t4a_item0", {23'd0, r.id, r.r2}, {23'd0, 9'd0, 32'h40A0_0000});
        r = got_at(1);
        check("t4a_item1", {23'd0, r.id, r.r2}, {23'd0, 9'd1, 32'h40B0_0000});
        check("t4a_issues", 64'(n_en - e0), 64'd2);
        check("t4a_done_once", 64'(n_done - d0), 64'd1);
        got.delete();
        start_job(9'd300, 9'd20, 10'd3, 32'h4110_0000);
        wait_done("t4b_done_timeout", 200);
        tick(4);
        check("t4b_count", 64'(got.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            r = got_at(i);
            check("t4b_item", {23'd0, r.id, r.r2}, {23'd0, 9'(i), 32'h40C0_0000 + 32'(i) * 32'h0010_0000});
        end

        // Reset mid-stream aborts the job and empties the FIFO
        rif.out_ready = 1'b0;
        start_job(9'd300, 9'd480, 10'd64, 32'h4110_0000);
        tick(25);
        check("t5_pre_valid", 64'(rif.out_valid), 64'd1);
        rst = 1'b0;
        tick(1);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_rd_en", 64'(mem_rd_en), 64'd0);
        check("t5_r2c_en", 64'(r2c_enable), 64'd0);
        check("t5_out_valid", 64'(rif.out_valid), 64'd0);
        check("t5_refx", 64'(refx), 64'd0);
        rst = 1'b1;
        tick(2);
        rif.out_ready = 1'b1;
        got.delete();
        start_job(9'd300, 9'd10, 10'd2, 32'h4110_0000);
        wait_done("t5_done_timeout", 200);
        tick(4);
        check("t5_count", 64'(got.size()), 64'd2);
        r = got_at(1);
        check("t5_item1", {23'd0, r.id, r.r2}, {23'd0, 9'd1, 32'h40B0_0000});

        // NaN is out of range, negative zero is in range
        mem[40] = {64'd0, 32'h7FC0_0000};
        mem[41] = {64'd0, 32'h8000_0000};
        got.delete();
        start_job(9'd300, 9'd40, 10'd2, 32'h4110_0000);
        wait_done("t6_done_timeout", 200);
        tick(4);
`ifdef CUTOFF_FILTER_EN
        check("t6_count", 64'(got.size()), 64'd1);
        r = got_at(0);
        check("t6_negzero", {22'd0, r.id, r.r2, r.ir}, {22'd0, 9'd1, 32'h8000_0000, 1'b1});
`else
        check("t6_count", 64'(got.size()), 64'd2);
        r = got_at(0);
        check("t6_nan", {22'd0, r.id, r.r2, r.ir}, {22'd0, 9'd0, 32'h7FC0_0000, 1'b0});
        r = got_at(1);
        check("t6_negzero", {22'd0, r.id, r.r2, r.ir}, {22'd0, 9'd1, 32'h8000_0000, 1'b1});
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
